// File: rtl/ir_load_sequencer.sv
// ir_load_sequencer
// Strobe sequencer for the M8522 IR board. It turns a fetch request into the
// ordered pulse train loadIR -> loadDRAM (DRADR) -> DRAM wait -> loadDRAM
// (A/B/J). It also arbitrates diagnostic load (06X) and read (13X) functions
// against fetches, so only one strobe is ever active on the IR board.
// All outputs come straight from flops. Each one is decoded from the next
// state, so every strobe is glitch-free and aligned with its state.

module ir_load_sequencer #(
    parameter int unsigned DRAM_LATENCY     = 1,  // 1..7 cycles, DRADR latch to valid douta
    parameter int unsigned DIAG_READ_CYCLES = 2   // 1..7 cycles 13X drives EBUS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetchReq,
    input  logic       fetchFromAD,
    input  logic       diagReq,
    input  logic       diagIsRead,
    input  logic [2:0] diagFunc,
    output logic       loadIR,
    output logic       mbXfer,
    output logic       loadDRAM,
    output logic       diagLoadFunc06X,
    output logic       diagReadFunc13X,
    output logic [2:0] diag,
    output logic       fetchBusy,
    output logic       fetchDone,
    output logic       diagAck,
    output logic       dramValid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_IR,
        S_LD_ADR,
        S_WAIT,
        S_LD_OUT,
        S_DONE,
        S_DG_LD,
        S_DG_RD
    } state_e;

    localparam logic [2:0] LAT_INIT  = 3'(DRAM_LATENCY);
    localparam logic [2:0] READ_INIT = 3'(DIAG_READ_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;          // shared by DRAM wait and diag read hold
    logic       src_q, src_d;          // latched fetchFromAD
    logic [2:0] diag_q, diag_d;        // latched diagFunc
    logic       dram_valid_q, dram_valid_d;
    logic       load_ir_q, load_ir_d;
    logic       mb_xfer_q, mb_xfer_d;
    logic       load_dram_q, load_dram_d;
    logic       dg_ld_q, dg_ld_d;
    logic       dg_rd_q, dg_rd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ack_q, ack_d;

    // Next-state, counter, latched-field and registered-output decode
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        src_d        = src_q;
        diag_d       = diag_q;
        dram_valid_d = dram_valid_q;

        case (state_q)
            S_IDLE: begin
                // Diag wins a simultaneous request.
                if (diagReq) begin
                    diag_d = diagFunc;
                    if (diagIsRead) begin
                        state_d = S_DG_RD;
                        cnt_d   = READ_INIT;
                    end else begin
                        // enIO_JRST/enAC may remap DRADR, so DRAM output is stale.
                        state_d      = S_DG_LD;
                        dram_valid_d = 1'b0;
                    end
                end else if (fetchReq) begin
                    src_d        = fetchFromAD;
                    dram_valid_d = 1'b0;
                    state_d      = S_LD_IR;
                end
            end
            S_LD_IR:  state_d = S_LD_ADR;
            S_LD_ADR: begin
                state_d = S_WAIT;
                cnt_d   = LAT_INIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = S_LD_OUT;
            end
            S_LD_OUT: begin
                state_d      = S_DONE;
                dram_valid_d = 1'b1;
            end
            S_DONE:   state_d = S_IDLE;
            S_DG_LD:  state_d = S_IDLE;
            S_DG_RD: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase

        // Strobes are decoded from the state being entered. Each output is
        // then high for exactly the cycles spent in that state.
        load_ir_d   = (state_d == S_LD_IR);
        mb_xfer_d   = (state_d == S_LD_IR) && src_d;
        load_dram_d = (state_d == S_LD_ADR) || (state_d == S_LD_OUT);
        dg_ld_d     = (state_d == S_DG_LD);
        dg_rd_d     = (state_d == S_DG_RD);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        ack_d       = (state_d == S_DG_LD) || ((state_d == S_DG_RD) && (cnt_d == 3'd1));
    end

    // Single state register. Reset aborts any operation with no done/ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            src_q        <= 1'b0;
            diag_q       <= 3'd0;
            dram_valid_q <= 1'b0;
            load_ir_q    <= 1'b0;
            mb_xfer_q    <= 1'b0;
            load_dram_q  <= 1'b0;
            dg_ld_q      <= 1'b0;
            dg_rd_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            src_q        <= src_d;
            diag_q       <= diag_d;
            dram_valid_q <= dram_valid_d;
            load_ir_q    <= load_ir_d;
            mb_xfer_q    <= mb_xfer_d;
            load_dram_q  <= load_dram_d;
            dg_ld_q      <= dg_ld_d;
            dg_rd_q      <= dg_rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ack_q        <= ack_d;
        end
    end

    assign loadIR          = load_ir_q;
    assign mbXfer          = mb_xfer_q;
    assign loadDRAM        = load_dram_q;
    assign diagLoadFunc06X = dg_ld_q;
    assign diagReadFunc13X = dg_rd_q;
    assign diag            = diag_q;
    assign fetchBusy       = busy_q;
    assign fetchDone       = done_q;
    assign diagAck         = ack_q;
    assign dramValid       = dram_valid_q;

endmodule

// File: tb/tb_ir_load_sequencer.sv
// Bench for ir_load_sequencer. It runs two instances: u0 with DRAM_LATENCY=1
// and u1 with DRAM_LATENCY=3. Both use DIAG_READ_CYCLES=2. Only one instance
// is exercised at a time. The driver pushes the expected strobe and
// completion records when it issues a request. A negedge monitor pops and
// compares a record whenever a DUT shows a strobe or a done/ack pulse.
// Cycle numbering: the request is sampled at edge N and loadIR appears in
// cycle N+1. In cycle N+1, cyc reads N+1 at the following negedge.

module tb_ir_load_sequencer;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam int RDC  = 2;

    typedef struct {
        int         inst;
        int         cyc;
        logic [3:0] strobes;   // {loadIR, loadDRAM, 06X, 13X}
        logic       mb;
        logic [2:0] dg;
        logic       dv;
    } strobe_t;

    typedef struct {
        int         inst;
        int         cyc;
        bit         is_diag;
        logic [2:0] dg;
        logic       dv;
    } done_t;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       fetch_req [2];
    logic       fetch_from_ad [2];
    logic       diag_req [2];
    logic       diag_is_read [2];
    logic [2:0] diag_func [2];
    logic       load_ir [2];
    logic       mb_xfer [2];
    logic       load_dram [2];
    logic       dg_ld [2];
    logic       dg_rd [2];
    logic [2:0] diag_o [2];
    logic       busy [2];
    logic       done [2];
    logic       ack [2];
    logic       dv [2];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    strobe_t sq[$];
    done_t   dq[$];
    int      idle_from [2];
    logic    dv_m [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ir_load_sequencer #(.DRAM_LATENCY(LAT0), .DIAG_READ_CYCLES(RDC)) u0 (
        .clk(clk), .reset(rst[0]),
        .fetchReq(fetch_req[0]), .fetchFromAD(fetch_from_ad[0]),
        .diagReq(diag_req[0]), .diagIsRead(diag_is_read[0]), .diagFunc(diag_func[0]),
        .loadIR(load_ir[0]), .mbXfer(mb_xfer[0]), .loadDRAM(load_dram[0]),
        .diagLoadFunc06X(dg_ld[0]), .diagReadFunc13X(dg_rd[0]), .diag(diag_o[0]),
        .fetchBusy(busy[0]), .fetchDone(done[0]), .diagAck(ack[0]), .dramValid(dv[0])
    );

    ir_load_sequencer #(.DRAM_LATENCY(LAT1), .DIAG_READ_CYCLES(RDC)) u1 (
        .clk(clk), .reset(rst[1]),
        .fetchReq(fetch_req[1]), .fetchFromAD(fetch_from_ad[1]),
        .diagReq(diag_req[1]), .diagIsRead(diag_is_read[1]), .diagFunc(diag_func[1]),
        .loadIR(load_ir[1]), .mbXfer(mb_xfer[1]), .loadDRAM(load_dram[1]),
        .diagLoadFunc06X(dg_ld[1]), .diagReadFunc13X(dg_rd[1]), .diag(diag_o[1]),
        .fetchBusy(busy[1]), .fetchDone(done[1]), .diagAck(ack[1]), .dramValid(dv[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat(input int inst);
        return (inst == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [11:0] all_outs(input int inst);
        return {load_ir[inst], mb_xfer[inst], load_dram[inst], dg_ld[inst], dg_rd[inst],
                busy[inst], done[inst], ack[inst], dv[inst], diag_o[inst]};
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_strobe(input int inst, input int c, input logic [3:0] s,
                               input logic mb, input logic [2:0] dg, input logic v);
        strobe_t e;
        e.inst = inst; e.cyc = c; e.strobes = s; e.mb = mb; e.dg = dg; e.dv = v;
        sq.push_back(e);
    endtask

    task automatic push_done(input int inst, input int c, input bit is_diag,
                             input logic [2:0] dg, input logic v);
        done_t e;
        e.inst = inst; e.cyc = c; e.is_diag = is_diag; e.dg = dg; e.dv = v;
        dq.push_back(e);
    endtask

    // Expected fetch sequence accepted at edge a. With abort set, only the
    // strobes issued before a reset lands in WAIT are expected.
    task automatic push_fetch(input int inst, input int a, input logic ad,
                              input bit abort, output int d);
        int l;
        l = lat(inst);
        push_strobe(inst, a + 1, 4'b1000, ad, 3'd0, 1'b0);
        push_strobe(inst, a + 2, 4'b0100, 1'b0, 3'd0, 1'b0);
        dv_m[inst] = 1'b0;
        d = a + 4 + l;
        if (!abort) begin
            push_strobe(inst, a + 3 + l, 4'b0100, 1'b0, 3'd0, 1'b0);
            push_done(inst, d, 1'b0, 3'd0, 1'b1);
            dv_m[inst]      = 1'b1;
            idle_from[inst] = d + 1;
        end
    endtask

    // Expected diag sequence accepted at edge a; returns the ack cycle.
    task automatic push_diag(input int inst, input int a, input bit rd,
                             input logic [2:0] f, output int k);
        if (rd) begin
            for (int i = 1; i <= RDC; i++)
                push_strobe(inst, a + i, 4'b0001, 1'b0, f, dv_m[inst]);
            k = a + RDC;
            push_done(inst, k, 1'b1, f, dv_m[inst]);
        end else begin
            dv_m[inst] = 1'b0;
            push_strobe(inst, a + 1, 4'b0010, 1'b0, f, 1'b0);
            k = a + 1;
            push_done(inst, k, 1'b1, f, 1'b0);
        end
        idle_from[inst] = k + 1;
    endtask

    function automatic int accept_edge(input int inst);
        return (cyc > idle_from[inst]) ? cyc : idle_from[inst];
    endfunction

    task automatic fetch_op(input int inst, input logic ad, input bit keep);
        int d;
        push_fetch(inst, accept_edge(inst), ad, 1'b0, d);
        fetch_from_ad[inst] = ad;
        fetch_req[inst]     = 1'b1;
        wait_cyc(d);
        if (!keep) fetch_req[inst] = 1'b0;
    endtask

    task automatic diag_op(input int inst, input bit rd, input logic [2:0] f);
        int k;
        push_diag(inst, accept_edge(inst), rd, f, k);
        diag_is_read[inst] = rd;
        diag_func[inst]    = f;
        diag_req[inst]     = 1'b1;
        wait_cyc(k);
        diag_req[inst]     = 1'b0;
    endtask

    // Monitor: compare a record whenever a strobe or completion pulse shows
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0] vec;
            vec = {load_ir[i], load_dram[i], dg_ld[i], dg_rd[i]};
            if (vec != 4'b0) begin
                check("strobe_exclusive", 32'($countones(vec)), 32'd1);
                check("strobe_busy", 32'(busy[i]), 32'd1);
                if (sq.size() == 0) begin
                    check("strobe_unexpected", 32'(vec), 32'd0);
                end else begin
                    strobe_t e;
                    e = sq.pop_front();
                    check("strobe_inst", i, e.inst);
                    check("strobe_cyc", cyc, e.cyc);
                    check("strobe_vec", 32'(vec), 32'(e.strobes));
                    if (e.strobes[3]) check("mbxfer", 32'(mb_xfer[i]), 32'(e.mb));
                    if (e.strobes[1] || e.strobes[0]) check("diag_field", 32'(diag_o[i]), 32'(e.dg));
                    check("strobe_dramvalid", 32'(dv[i]), 32'(e.dv));
                end
            end
            if (done[i] || ack[i]) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", 32'({done[i], ack[i]}), 32'd0);
                end else begin
                    done_t e;
                    e = dq.pop_front();
                    check("done_inst", i, e.inst);
                    check("done_cyc", cyc, e.cyc);
                    check("done_kind", 32'({done[i], ack[i]}), e.is_diag ? 32'd1 : 32'd2);
                    if (e.is_diag) check("ack_diag", 32'(diag_o[i]), 32'(e.dg));
                    check("done_dramvalid", 32'(dv[i]), 32'(e.dv));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, d, k;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; fetch_req[i] = 1'b0; fetch_from_ad[i] = 1'b0;
            diag_req[i] = 1'b0; diag_is_read[i] = 1'b0; diag_func[i] = 3'd0;
            idle_from[i] = 0; dv_m[i] = 1'b0;
        end
        // Requests during reset must be ignored.
        fetch_req[0] = 1'b1;
        diag_req[1]  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs_u0", 32'(all_outs(0)), 32'd0);
        check("reset_outs_u1", 32'(all_outs(1)), 32'd0);
        fetch_req[0] = 1'b0;
        diag_req[1]  = 1'b0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_outs_u0", 32'(all_outs(0)), 32'd0);

        // Test 1: L=1 fetch from AD.
        fetch_op(0, 1'b1, 1'b0);
        @(negedge clk);
        // Diag read keeps dramValid high.
        diag_op(0, 1'b1, 3'b011);
        @(negedge clk);

        // Test 2: L=3 fetch from cacheData.
        fetch_op(1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Test 3: simultaneous diag read and fetch; diag wins, and diag
        // holds its latched value when diagFunc changes mid-read.
        a = accept_edge(1);
        push_diag(1, a, 1'b1, 3'b101, k);
        push_fetch(1, idle_from[1], 1'b1, 1'b0, d);
        diag_is_read[1] = 1'b1; diag_func[1] = 3'b101; diag_req[1] = 1'b1;
        fetch_from_ad[1] = 1'b1; fetch_req[1] = 1'b1;
        wait_cyc(a + 1);
        diag_func[1] = 3'b010;
        wait_cyc(k);
        diag_req[1] = 1'b0;
        wait_cyc(d);
        fetch_req[1] = 1'b0;
        @(negedge clk);

        // Test 4: diag load after a completed fetch drops dramValid.
        diag_op(1, 1'b0, 3'b110);
        @(negedge clk);
        check("dramvalid_after_06x", 32'(dv[1]), 32'd0);

        // Test 5: reset in WAIT aborts with no fetchDone.
        a = accept_edge(1);
        push_fetch(1, a, 1'b1, 1'b1, d);
        fetch_from_ad[1] = 1'b1; fetch_req[1] = 1'b1;
        wait_cyc(a + 4);
        check("in_wait_busy", 32'(busy[1]), 32'd1);
        #1 rst[1] = 1'b1;
        #1 check("abort_outs", 32'(all_outs(1)), 32'd0);
        fetch_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        wait_cyc(d + 2);
        check("post_abort_outs", 32'(all_outs(1)), 32'd0);
        idle_from[1] = cyc;
        fetch_op(1, 1'b1, 1'b0);
        @(negedge clk);

        // Test 6: fetchReq held across back-to-back fetches at L=1.
        fetch_op(0, 1'b1, 1'b1);
        fetch_op(0, 1'b0, 1'b1);
        fetch_op(0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);

        check("strobe_queue_empty", sq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
